// File: rtl/min2_pkg.sv
// Shared types, default widths and helpers for the streaming two-minimum finder.
package min2_pkg;

  localparam int unsigned DEF_DATA_W = 11;
  localparam int unsigned DEF_IDX_W  = 7;

  // Ordered candidate pair: min1 <= min2, idx1/idx2 are global indices.
  typedef struct packed {
    logic [DEF_DATA_W-1:0] min1;
    logic [DEF_DATA_W-1:0] min2;
    logic [DEF_IDX_W-1:0]  idx1;
    logic [DEF_IDX_W-1:0]  idx2;
  } min_pair_t;

  // Value reported for an unused slot.
  localparam logic [DEF_DATA_W-1:0] EMPTY = '1;

  // Number of lane-select bits for a power-of-two lane count.
  function automatic int unsigned lanes_log2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/min2_merge.sv
// Combinational merge of two ordered pairs into one ordered pair.
// Operand a always carries the lower indices, so a wins every value tie.
// Invalid slots never win and are reported as all-ones with index 0.
module min2_merge
  import min2_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned IDX_W  = DEF_IDX_W
) (
  input  logic              a_v1,
  input  logic              a_v2,
  input  logic [DATA_W-1:0] a_min1,
  input  logic [DATA_W-1:0] a_min2,
  input  logic [IDX_W-1:0]  a_idx1,
  input  logic [IDX_W-1:0]  a_idx2,
  input  logic              b_v1,
  input  logic              b_v2,
  input  logic [DATA_W-1:0] b_min1,
  input  logic [DATA_W-1:0] b_min2,
  input  logic [IDX_W-1:0]  b_idx1,
  input  logic [IDX_W-1:0]  b_idx2,
  output logic              r_v1,
  output logic              r_v2,
  output logic [DATA_W-1:0] r_min1,
  output logic [DATA_W-1:0] r_min2,
  output logic [IDX_W-1:0]  r_idx1,
  output logic [IDX_W-1:0]  r_idx2
);

  logic              a_first;
  logic              sec_x;
  logic              f_v;
  logic [DATA_W-1:0] f_m;
  logic [IDX_W-1:0]  f_i;
  logic              p_v;
  logic [DATA_W-1:0] p_m;
  logic [IDX_W-1:0]  p_i;
  logic              q_v;
  logic [DATA_W-1:0] q_m;
  logic [IDX_W-1:0]  q_i;
  logic              s_v;
  logic [DATA_W-1:0] s_m;
  logic [IDX_W-1:0]  s_i;

  // Pick the overall minimum, then the better of the two remaining heads.
  always_comb begin
    a_first = a_v1 && (!b_v1 || (a_min1 <= b_min1));
    if (a_first) begin
      f_v = a_v1;  f_m = a_min1;  f_i = a_idx1;
      p_v = a_v2;  p_m = a_min2;  p_i = a_idx2;
      q_v = b_v1;  q_m = b_min1;  q_i = b_idx1;
    end else begin
      f_v = b_v1;  f_m = b_min1;  f_i = b_idx1;
      p_v = a_v1;  p_m = a_min1;  p_i = a_idx1;
      q_v = b_v2;  q_m = b_min2;  q_i = b_idx2;
    end
    // p always comes from operand a (lower indices), so it wins ties.
    sec_x = p_v && (!q_v || (p_m <= q_m));
    s_v   = sec_x ? p_v : q_v;
    s_m   = sec_x ? p_m : q_m;
    s_i   = sec_x ? p_i : q_i;
  end

  assign r_v1   = f_v;
  assign r_min1 = f_v ? f_m : '1;
  assign r_idx1 = f_v ? f_i : '0;
  assign r_v2   = s_v;
  assign r_min2 = s_v ? s_m : '1;
  assign r_idx2 = s_v ? s_i : '0;

endmodule

// File: rtl/stream_min2_finder.sv
// Streaming smallest/second-smallest finder over in_last-terminated bursts,
// LANES magnitudes per beat, one result per message via valid/ready.
module stream_min2_finder
  import min2_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned LANES      = 4,
  parameter int unsigned IDX_W      = DEF_IDX_W,
  parameter bit          ZERO_EMPTY = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_data,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       min1,
  output logic [DATA_W-1:0]       min2,
  output logic [IDX_W-1:0]        min1_idx,
  output logic [IDX_W-1:0]        min2_idx,
  output logic [IDX_W:0]          cand_cnt,
  output logic                    ovf
);

  localparam int unsigned LL = lanes_log2(LANES);
  localparam int unsigned BW = IDX_W - LL;
  localparam logic [BW-1:0] BeatMax = '1;
  localparam logic [IDX_W+1:0] CntMax = (IDX_W + 2)'(1) << IDX_W;

  typedef enum logic [0:0] {StAcc, StDone} state_e;

  state_e state_q, state_d;

  logic              run_v1_q, run_v2_q;
  logic [DATA_W-1:0] run_m1_q, run_m2_q;
  logic [IDX_W-1:0]  run_i1_q, run_i2_q;
  logic              run_v1_d, run_v2_d;
  logic [DATA_W-1:0] run_m1_d, run_m2_d;
  logic [IDX_W-1:0]  run_i1_d, run_i2_d;
  logic [BW-1:0]     beat_cnt_q;
  logic              wrap_q;
  logic              ovf_q;
  logic [IDX_W:0]    cnt_q, cnt_d;
  logic [LL:0]       pop;
  logic [IDX_W+1:0]  cnt_sum;
  logic [LANES-1:0]  lane_ok;
  logic              accept, release_res;

  // Heap-ordered merge tree: node n merges 2n (lower lanes) and 2n+1.
  logic              nd_v1 [1:2*LANES-1];
  logic              nd_v2 [1:2*LANES-1];
  logic [DATA_W-1:0] nd_m1 [1:2*LANES-1];
  logic [DATA_W-1:0] nd_m2 [1:2*LANES-1];
  logic [IDX_W-1:0]  nd_i1 [1:2*LANES-1];
  logic [IDX_W-1:0]  nd_i2 [1:2*LANES-1];

  assign in_ready    = (state_q == StAcc);
  assign out_valid   = (state_q == StDone);
  assign accept      = in_valid && in_ready;
  assign release_res = out_valid && out_ready;

  for (genvar k = 0; k < LANES; k++) begin : g_leaf
    logic [DATA_W-1:0] lane;
    assign lane       = in_data[k*DATA_W +: DATA_W];
    // Beats after the index space wrapped never become candidates.
    assign lane_ok[k] = !wrap_q && (!ZERO_EMPTY || (lane != '0));
    assign nd_v1[LANES+k] = lane_ok[k];
    assign nd_m1[LANES+k] = lane_ok[k] ? lane : '1;
    assign nd_i1[LANES+k] = lane_ok[k] ? {beat_cnt_q, LL'(k)} : '0;
    assign nd_v2[LANES+k] = 1'b0;
    assign nd_m2[LANES+k] = '1;
    assign nd_i2[LANES+k] = '0;
  end

  for (genvar n = 1; n < LANES; n++) begin : g_tree
    min2_merge #(
      .DATA_W(DATA_W),
      .IDX_W (IDX_W)
    ) u_merge (
      .a_v1  (nd_v1[2*n]),
      .a_v2  (nd_v2[2*n]),
      .a_min1(nd_m1[2*n]),
      .a_min2(nd_m2[2*n]),
      .a_idx1(nd_i1[2*n]),
      .a_idx2(nd_i2[2*n]),
      .b_v1  (nd_v1[2*n+1]),
      .b_v2  (nd_v2[2*n+1]),
      .b_min1(nd_m1[2*n+1]),
      .b_min2(nd_m2[2*n+1]),
      .b_idx1(nd_i1[2*n+1]),
      .b_idx2(nd_i2[2*n+1]),
      .r_v1  (nd_v1[n]),
      .r_v2  (nd_v2[n]),
      .r_min1(nd_m1[n]),
      .r_min2(nd_m2[n]),
      .r_idx1(nd_i1[n]),
      .r_idx2(nd_i2[n])
    );
  end

  // Running pair holds earlier beats, hence the lower indices: it is operand a.
  min2_merge #(
    .DATA_W(DATA_W),
    .IDX_W (IDX_W)
  ) u_run_merge (
    .a_v1  (run_v1_q),
    .a_v2  (run_v2_q),
    .a_min1(run_m1_q),
    .a_min2(run_m2_q),
    .a_idx1(run_i1_q),
    .a_idx2(run_i2_q),
    .b_v1  (nd_v1[1]),
    .b_v2  (nd_v2[1]),
    .b_min1(nd_m1[1]),
    .b_min2(nd_m2[1]),
    .b_idx1(nd_i1[1]),
    .b_idx2(nd_i2[1]),
    .r_v1  (run_v1_d),
    .r_v2  (run_v2_d),
    .r_min1(run_m1_d),
    .r_min2(run_m2_d),
    .r_idx1(run_i1_d),
    .r_idx2(run_i2_d)
  );

  // Saturating candidate count for the accepted beat.
  always_comb begin
    pop = '0;
    for (int k = 0; k < LANES; k++) begin
      pop = pop + (LL + 1)'(lane_ok[k]);
    end
    cnt_sum = {1'b0, cnt_q} + (IDX_W + 2)'(pop);
    cnt_d   = (cnt_sum > CntMax) ? CntMax[IDX_W:0] : cnt_sum[IDX_W:0];
  end

  // Next-state logic: accumulate until in_last, hold result until taken.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StAcc:   if (accept && in_last) state_d = StDone;
      StDone:  if (release_res)       state_d = StAcc;
      default: state_d = StAcc;
    endcase
  end

  // State, running pair, beat counter and message flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StAcc;
      run_v1_q   <= 1'b0;
      run_v2_q   <= 1'b0;
      run_m1_q   <= '1;
      run_m2_q   <= '1;
      run_i1_q   <= '0;
      run_i2_q   <= '0;
      beat_cnt_q <= '0;
      wrap_q     <= 1'b0;
      ovf_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        run_v1_q   <= run_v1_d;
        run_v2_q   <= run_v2_d;
        run_m1_q   <= run_m1_d;
        run_m2_q   <= run_m2_d;
        run_i1_q   <= run_i1_d;
        run_i2_q   <= run_i2_d;
        cnt_q      <= cnt_d;
        ovf_q      <= ovf_q | wrap_q;
        beat_cnt_q <= beat_cnt_q + 1'b1;
        if (beat_cnt_q == BeatMax) wrap_q <= 1'b1;
      end else if (release_res) begin
        run_v1_q   <= 1'b0;
        run_v2_q   <= 1'b0;
        run_m1_q   <= '1;
        run_m2_q   <= '1;
        run_i1_q   <= '0;
        run_i2_q   <= '0;
        beat_cnt_q <= '0;
        wrap_q     <= 1'b0;
        ovf_q      <= 1'b0;
        cnt_q      <= '0;
      end
    end
  end

  assign min1     = run_m1_q;
  assign min2     = run_m2_q;
  assign min1_idx = run_i1_q;
  assign min2_idx = run_i2_q;
  assign cand_cnt = cnt_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_stream_min2_finder.sv
// Scoreboard bench: a reference model predicts each message result when its
// last beat is accepted; the monitor pops and compares on each handshake.
module tb_stream_min2_finder;
  import min2_pkg::*;

  localparam int DW = 11;
  localparam int L  = 4;
  localparam int IW = 7;
  localparam int NB = 32;  // beats that fit in the index space

  typedef struct {
    min_pair_t  p;
    logic [7:0] cnt;
    logic       ovf;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic [L*DW-1:0] in_data;
  logic            in_last;
  logic            out_ready;
  logic            in_ready, out_valid, ovf;
  logic [DW-1:0]   min1, min2;
  logic [IW-1:0]   min1_idx, min2_idx;
  logic [IW:0]     cand_cnt;
  logic            in_ready_nz, out_valid_nz, ovf_nz;
  logic [DW-1:0]   min1_nz, min2_nz;
  logic [IW-1:0]   min1_idx_nz, min2_idx_nz;
  logic [IW:0]     cand_cnt_nz;

  int n_checks = 0;
  int n_errors = 0;

  logic [L*DW-1:0] msg_q[$];
  exp_t            exp_q[$];
  exp_t            exp_nz_q[$];
  exp_t            mon_e;

  stream_min2_finder #(.DATA_W(DW), .LANES(L), .IDX_W(IW), .ZERO_EMPTY(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .min1(min1),
    .min2(min2), .min1_idx(min1_idx), .min2_idx(min2_idx), .cand_cnt(cand_cnt), .ovf(ovf)
  );

  stream_min2_finder #(.DATA_W(DW), .LANES(L), .IDX_W(IW), .ZERO_EMPTY(1'b0)) dut_nz (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_nz), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid_nz), .out_ready(out_ready), .min1(min1_nz),
    .min2(min2_nz), .min1_idx(min1_idx_nz), .min2_idx(min2_idx_nz),
    .cand_cnt(cand_cnt_nz), .ovf(ovf_nz)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [L*DW-1:0] pack4(input int l3, input int l2, input int l1,
                                            input int l0);
    return {DW'(l3), DW'(l2), DW'(l1), DW'(l0)};
  endfunction

  // Reference: scan candidates in index order; strict compares keep the lower index on ties.
  function automatic exp_t model(input bit ze);
    exp_t e;
    bit h1, h2;
    int cnt;
    logic [DW-1:0] v;
    h1 = 0; h2 = 0; cnt = 0;
    e.p.min1 = EMPTY; e.p.min2 = EMPTY; e.p.idx1 = '0; e.p.idx2 = '0;
    e.ovf = (msg_q.size() > NB);
    for (int b = 0; b < msg_q.size(); b++) begin
      if (b < NB) begin
        for (int k = 0; k < L; k++) begin
          v = msg_q[b][k*DW +: DW];
          if (!(ze && v == 0)) begin
            cnt++;
            if (!h1 || v < e.p.min1) begin
              if (h1) begin
                e.p.min2 = e.p.min1; e.p.idx2 = e.p.idx1; h2 = 1;
              end
              e.p.min1 = v; e.p.idx1 = IW'(b*L + k); h1 = 1;
            end else if (!h2 || v < e.p.min2) begin
              e.p.min2 = v; e.p.idx2 = IW'(b*L + k); h2 = 1;
            end
          end
        end
      end
    end
    if (cnt > (1 << IW)) cnt = 1 << IW;
    e.cnt = 8'(cnt);
    return e;
  endfunction

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send_beat(input logic [L*DW-1:0] d, input logic last);
    bit acc;
    int budget;
    acc = 0; budget = 0;
    in_valid = 1'b1; in_data = d; in_last = last;
    while (!acc && budget < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      budget++;
    end
    in_valid = 1'b0; in_last = 1'b0;
    if (!acc) begin
      check_val("accept_timeout", 0, 1);
    end else begin
      msg_q.push_back(d);
      if (last) begin
        exp_q.push_back(model(1'b1));
        exp_nz_q.push_back(model(1'b0));
        msg_q.delete();
      end
    end
  endtask

  task automatic wait_drain();
    int b;
    b = 0;
    while (exp_q.size() != 0 && b < 100) begin
      @(posedge clk);
      b++;
    end
    #1;
    check_val("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic check_reset_state(input string tag);
    @(negedge clk);
    check_val({tag, "_in_ready"}, in_ready, 1);
    check_val({tag, "_out_valid"}, out_valid, 0);
    check_val({tag, "_min1"}, min1, 2047);
    check_val({tag, "_min2"}, min2, 2047);
    check_val({tag, "_idx"}, {min1_idx, min2_idx}, 0);
    check_val({tag, "_cnt"}, cand_cnt, 0);
    check_val({tag, "_ovf"}, ovf, 0);
  endtask

  // Scoreboard compare on every result handshake.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_out", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check_val("min1", min1, mon_e.p.min1);
        check_val("min2", min2, mon_e.p.min2);
        check_val("min1_idx", min1_idx, mon_e.p.idx1);
        check_val("min2_idx", min2_idx, mon_e.p.idx2);
        check_val("cand_cnt", cand_cnt, mon_e.cnt);
        check_val("ovf", ovf, mon_e.ovf);
      end
      if (exp_nz_q.size() != 0) begin
        mon_e = exp_nz_q.pop_front();
        check_val("nz_out_valid", out_valid_nz, 1);
        check_val("nz_min1", min1_nz, mon_e.p.min1);
        check_val("nz_min2", min2_nz, mon_e.p.min2);
        check_val("nz_min1_idx", min1_idx_nz, mon_e.p.idx1);
        check_val("nz_min2_idx", min2_idx_nz, mon_e.p.idx2);
        check_val("nz_cand_cnt", cand_cnt_nz, mon_e.cnt);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [L*DW-1:0] d;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    check_reset_state("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Single beat with an empty lane.
    send_beat(pack4(40, 7, 0, 9), 1'b1);
    wait_drain();

    // Two beats with a value tie in the first.
    send_beat(pack4(5, 5, 20, 30), 1'b0);
    send_beat(pack4(70, 60, 50, 1), 1'b1);
    wait_drain();

    // All-empty message.
    send_beat(pack4(0, 0, 0, 0), 1'b1);
    wait_drain();

    // Result held while the consumer stalls; offered beats must not be taken.
    out_ready = 1'b0;
    send_beat(pack4(100, 200, 3, 4), 1'b1);
    in_valid = 1'b1; in_data = pack4(1, 1, 1, 1); in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val("hold_out_valid", out_valid, 1);
      check_val("hold_in_ready", in_ready, 0);
      check_val("hold_min1", min1, exp_q[0].p.min1);
      check_val("hold_min2_idx", min2_idx, exp_q[0].p.idx2);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    wait_drain();
    send_beat(pack4(9, 8, 7, 6), 1'b1);
    wait_drain();

    // Index-space overflow: beats from the 33rd onward are excluded.
    for (int b = 0; b < 33; b++) begin
      d = pack4($urandom_range(2, 2047), $urandom_range(2, 2047),
                $urandom_range(2, 2047), $urandom_range(2, 2047));
      if (b == 32) d = pack4(1, 1, 1, 1);
      send_beat(d, 1'b0);
    end
    send_beat(pack4(1, 1, 1, 1), 1'b1);
    wait_drain();

    // Reset in the middle of a message.
    send_beat(pack4(1, 1, 1, 1), 1'b0);
    send_beat(pack4(2, 2, 2, 2), 1'b0);
    rst = 1'b1;
    msg_q.delete();
    @(posedge clk);
    check_reset_state("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    send_beat(pack4(300, 400, 500, 600), 1'b1);
    wait_drain();

    // A few random messages with some empty lanes.
    for (int m = 0; m < 5; m++) begin
      int nb;
      nb = $urandom_range(1, 4);
      for (int b = 0; b < nb; b++) begin
        d = '0;
        for (int k = 0; k < L; k++) begin
          if ($urandom_range(0, 3) != 0) d[k*DW +: DW] = DW'($urandom_range(0, 60));
        end
        send_beat(d, (b == nb - 1));
      end
      wait_drain();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
